// File: rtl/fifo_word_unpacker.sv
// Pops WORD_W-bit words from a standard-read FIFO and serialises each into ELEMS elements,
// element 0 = low bits first, with a hold + prefetch buffer for gapless output.
module fifo_word_unpacker #(
    parameter int WORD_W      = 256,
    parameter int ELEM_W      = 32,
    parameter int FRAME_WORDS = 4
) (
    input  logic              user_clk,
    input  logic              peripheral_aresetn,
    input  logic              fifo_not_empty,
    output logic              fifo_rd_en,
    input  logic [WORD_W-1:0] fifo_dout,
    output logic [ELEM_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              m_frame_last
);

    localparam int ELEMS = WORD_W / ELEM_W;
    localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int FRM_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ELEMS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_WORDS - 1);

    typedef logic [ELEMS-1:0][ELEM_W-1:0] word_t;

    word_t            hold_q, hold_d;
    word_t            pre_q, pre_d;
    logic             hold_valid_q, hold_valid_d;
    logic             pre_valid_q, pre_valid_d;
    logic             rd_pending_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;

    logic [1:0] occupancy;
    logic       accept;
    logic       release_word;

    // Words held, prefetched or in flight; at most one read is ever outstanding.
    // The reset term keeps the strobe low while reset is asserted.
    always_comb begin
        occupancy    = {1'b0, hold_valid_q} + {1'b0, pre_valid_q} + {1'b0, rd_pending_q};
        fifo_rd_en   = peripheral_aresetn && fifo_not_empty && (occupancy <= 2'd1);
        accept       = hold_valid_q && m_ready;
        release_word = accept && (idx_q == IDX_LAST);
    end

    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        hold_d       = hold_q;
        pre_d        = pre_q;
        hold_valid_d = hold_valid_q;
        pre_valid_d  = pre_valid_q;
        idx_d        = idx_q;
        frame_cnt_d  = frame_cnt_q;

        if (accept) begin
            idx_d = release_word ? '0 : idx_q + 1'b1;
        end

        if (release_word) begin
            frame_cnt_d = (frame_cnt_q == FRM_LAST) ? '0 : frame_cnt_q + 1'b1;
            if (pre_valid_q) begin
                hold_d       = pre_q;
                hold_valid_d = 1'b1;
                pre_valid_d  = 1'b0;
            end else begin
                hold_valid_d = 1'b0;
            end
        end

        // Capture sees hold after any same-cycle release, so a word arriving while
        // the last element leaves lands in the freed slot rather than being dropped.
        if (rd_pending_q) begin
            if (!hold_valid_d) begin
                hold_d       = fifo_dout;
                hold_valid_d = 1'b1;
            end else begin
                pre_d       = fifo_dout;
                pre_valid_d = 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    // NOTE: the data buffers are reset too so m_data reads 0 out of reset.
    always_ff @(posedge user_clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            hold_q       <= '0;
            pre_q        <= '0;
            hold_valid_q <= 1'b0;
            pre_valid_q  <= 1'b0;
            rd_pending_q <= 1'b0;
            idx_q        <= '0;
            frame_cnt_q  <= '0;
        end else begin
            hold_q       <= hold_d;
            pre_q        <= pre_d;
            hold_valid_q <= hold_valid_d;
            pre_valid_q  <= pre_valid_d;
            rd_pending_q <= fifo_rd_en;
            idx_q        <= idx_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    always_comb begin
        m_valid      = hold_valid_q;
        m_data       = hold_q[idx_q];
        m_last       = hold_valid_q && (idx_q == IDX_LAST);
        m_frame_last = m_last && (frame_cnt_q == FRM_LAST);
    end

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Directed bench for fifo_word_unpacker: a small non-FWFT FIFO model feeds the DUT and a
// scoreboard checks element order, word/frame markers, read count and reset behaviour.
module tb_fifo_word_unpacker;

    localparam int WORD_W = 256;
    localparam int ELEM_W = 32;
    localparam int FRAME_WORDS = 4;

    logic              clk;
    logic              rst_n;
    logic              fifo_not_empty;
    logic              fifo_rd_en;
    logic [WORD_W-1:0] fifo_dout = '0;
    logic [ELEM_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              m_frame_last;

    int n_checks = 0;
    int n_errors = 0;

    // FIFO model: pushes come from the stimulus process, pops from the read strobe.
    logic [WORD_W-1:0] mem [16];
    logic [3:0]        wr_ptr = '0;
    logic [3:0]        rd_ptr = '0;
    int                rd_cnt = 0;

    assign fifo_not_empty = (wr_ptr != rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 4'd1;
            rd_cnt    <= rd_cnt + 1;
        end
    end

    fifo_word_unpacker #(
        .WORD_W(WORD_W),
        .ELEM_W(ELEM_W),
        .FRAME_WORDS(FRAME_WORDS)
    ) dut (
        .user_clk(clk),
        .peripheral_aresetn(rst_n),
        .fifo_not_empty(fifo_not_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_last(m_last),
        .m_frame_last(m_frame_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WORD_W-1:0] make_word(input logic [31:0] base);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < WORD_W / ELEM_W; k++) w[k*ELEM_W +: ELEM_W] = base + 32'(k);
        return w;
    endfunction

    // Pushes n consecutive words; element j of the whole run is base + j.
    task automatic push_words(input int n, input logic [31:0] base);
        for (int w = 0; w < n; w++) begin
            mem[wr_ptr] = make_word(base + 32'(8 * w));
            wr_ptr      = wr_ptr + 4'd1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; samples outputs there, drives m_ready from the 4-cycle pattern,
    // and scoreboards n_elems elements starting at value base (frame restarts at element 0).
    task automatic run_stream(input int n_elems, input logic [31:0] base,
                              input logic [3:0] pat, output int n_frame);
        int  n;
        int  cyc;
        bit  gapless;
        n       = 0;
        cyc     = 0;
        n_frame = 0;
        gapless = (pat == 4'hF);
        while (n < n_elems && cyc < 1000) begin
            m_ready = pat[cyc % 4];
            if (m_valid) begin
                check("data", m_data, base + 32'(n));
                check("last", 32'(m_last), 32'((n % 8) == 7));
                check("frame_last", 32'(m_frame_last), 32'(((n % 8) == 7) && (((n / 8) % 4) == 3)));
            end else if (gapless && n > 0) begin
                check("gap", 32'(m_valid), 32'd1);
            end
            if (m_valid && m_ready) begin
                if (m_frame_last) n_frame++;
                n++;
            end
            cyc++;
            @(negedge clk);
        end
        check("stream_count", 32'(n), 32'(n_elems));
    endtask

    initial begin
        int nf;
        int snap;
        rst_n   = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_rd_en", 32'(fifo_rd_en), 0);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_data", m_data, 0);
        check("rst_last", 32'(m_last), 0);
        check("rst_frame_last", 32'(m_frame_last), 0);

        // One word, latency and drain
        m_ready = 1'b1;
        snap    = rd_cnt;
        push_words(1, 32'd1);
        #1;
        check("lat_c0_rd_en", 32'(fifo_rd_en), 1);
        check("lat_c0_valid", 32'(m_valid), 0);
        @(negedge clk);
        check("lat_c1_rd_en", 32'(fifo_rd_en), 0);
        check("lat_c1_valid", 32'(m_valid), 0);
        @(negedge clk);
        check("lat_c2_valid", 32'(m_valid), 1);
        run_stream(8, 32'd1, 4'hF, nf);
        check("one_word_drained", 32'(m_valid), 0);
        check("one_word_reads", 32'(rd_cnt - snap), 1);

        // Four preloaded words, gapless, one frame end
        do_reset();
        m_ready = 1'b0;
        push_words(4, 32'h200);
        repeat (6) @(negedge clk);
        run_stream(32, 32'h200, 4'hF, nf);
        check("four_frame_ends", 32'(nf), 1);
        check("four_drained", 32'(m_valid), 0);

        // Two words under ready pattern 1,0,0,1
        do_reset();
        snap = rd_cnt;
        push_words(2, 32'h300);
        run_stream(16, 32'h300, 4'b1001, nf);
        check("toggle_reads", 32'(rd_cnt - snap), 2);

        // Full backpressure with five words queued
        do_reset();
        m_ready = 1'b0;
        snap    = rd_cnt;
        push_words(5, 32'h400);
        repeat (20) @(negedge clk);
        check("bp_reads", 32'(rd_cnt - snap), 2);
        check("bp_rd_en_idle", 32'(fifo_rd_en), 0);
        check("bp_valid", 32'(m_valid), 1);
        check("bp_data_held", m_data, 32'h400);
        run_stream(40, 32'h400, 4'hF, nf);
        check("bp_drained", 32'(m_valid), 0);
        check("bp_reads_total", 32'(rd_cnt - snap), 5);

        // Six words streamed: only word 4 ends a frame
        do_reset();
        m_ready = 1'b1;
        push_words(6, 32'h800);
        run_stream(48, 32'h800, 4'hF, nf);
        check("six_frame_ends", 32'(nf), 1);

        // Asynchronous reset mid-word, then restart
        do_reset();
        m_ready = 1'b1;
        push_words(3, 32'h500);
        run_stream(19, 32'h500, 4'hF, nf);
        check("mid_word_data", m_data, 32'h500 + 32'd19);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(m_valid), 0);
        check("async_data", m_data, 0);
        check("async_last", 32'(m_last), 0);
        check("async_rd_en", 32'(fifo_rd_en), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_words(4, 32'h600);
        run_stream(32, 32'h600, 4'hF, nf);
        check("restart_frame_ends", 32'(nf), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
